// File: rtl/vicii_boot_sequencer_if.sv
// Bus bundle between the VIC-II boot sequencer and the RAM / VIC-II / register
// table it drives. The master modport is the sequencer side.
// Optional readback signals exist only when SEQ_VERIFY_EN is defined.
interface vicii_boot_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [IDX_WIDTH-1:0]  reg_idx;
  logic [13:0]           reg_entry;
  logic [5:0]            vic_ain;
  logic [DATA_WIDTH-1:0] vic_di;
  logic                  vic_cs;
  logic                  vic_we;
`ifdef SEQ_VERIFY_EN
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  err;

  modport master (
    input  start, reg_entry, ram_rdata,
    output busy, done, ram_addr, ram_wdata, ram_we, reg_idx,
           vic_ain, vic_di, vic_cs, vic_we, err
  );

  modport slave (
    output start, reg_entry, ram_rdata,
    input  busy, done, ram_addr, ram_wdata, ram_we, reg_idx,
           vic_ain, vic_di, vic_cs, vic_we, err
  );
`else
  modport master (
    input  start, reg_entry,
    output busy, done, ram_addr, ram_wdata, ram_we, reg_idx,
           vic_ain, vic_di, vic_cs, vic_we
  );

  modport slave (
    output start, reg_entry,
    input  busy, done, ram_addr, ram_wdata, ram_we, reg_idx,
           vic_ain, vic_di, vic_cs, vic_we
  );
`endif
endinterface

// File: rtl/vicii_boot_sequencer.sv
// VIC-II boot sequencer: CPU-less bus master that fills video/colour RAM with
// a tagged incrementing pattern, idles one stride, then replays a table of
// VIC-II register writes. Every bus access is held for STRIDE clocks.
// Optional feature macro: SEQ_VERIFY_EN adds a VERIFY pass after the fill that
// reads each word back and raises a sticky err flag on any mismatch.
module vicii_boot_sequencer #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 12,
  parameter int                    FILL_LEN   = 1000,
  parameter logic [DATA_WIDTH-1:0] FILL_TAG   = 12'h800,
  parameter int                    STRIDE     = 8,
  parameter int                    NREG       = 5,
  parameter int                    IDX_WIDTH  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  vicii_boot_sequencer_if.master  bus
);

  localparam int IW = (FILL_LEN > 0) ? $clog2(FILL_LEN + 1) : 1;
  localparam int CW = $clog2(STRIDE);

  localparam logic [IW-1:0]        I_LAST = IW'(FILL_LEN - 1);
  localparam logic [CW-1:0]        C_LAST = CW'(STRIDE - 1);
  localparam logic [CW-1:0]        C_PRE  = CW'(STRIDE - 2);
  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'((NREG > 0) ? NREG - 1 : 0);

`ifdef SEQ_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_VERIFY, S_GAP, S_REGS, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_GAP, S_REGS, S_DONE
  } state_t;
`endif

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         i;
  logic [IDX_WIDTH-1:0]  k;
  logic [IDX_WIDTH-1:0]  reg_idx;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [5:0]            vic_ain;
  logic [DATA_WIDTH-1:0] vic_di;
  logic                  vic_cs;
  logic                  vic_we;
`ifdef SEQ_VERIFY_EN
  logic                  err;
`endif

  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         i_nxt;
  logic [IDX_WIDTH-1:0]  k_nxt;

  assign cnt_nxt = cnt + CW'(1);
  assign i_nxt   = i + IW'(1);
  assign k_nxt   = k + IDX_WIDTH'(1);

  // Fill pattern: tag in the upper bits, low byte of the word index below it.
  function automatic logic [DATA_WIDTH-1:0] fill_word(input logic [IW-1:0] idx);
    return FILL_TAG | (DATA_WIDTH'(idx) & DATA_WIDTH'(8'hFF));
  endfunction

  // RAM address is the word index truncated to the address width, so an
  // oversized fill wraps around the RAM.
  function automatic logic [ADDR_WIDTH-1:0] fill_addr(input logic [IW-1:0] idx);
    return ADDR_WIDTH'(idx);
  endfunction

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.ram_we    = ram_we;
  assign bus.reg_idx   = reg_idx;
  assign bus.vic_ain   = vic_ain;
  assign bus.vic_di    = vic_di;
  assign bus.vic_cs    = vic_cs;
  assign bus.vic_we    = vic_we;
`ifdef SEQ_VERIFY_EN
  assign bus.err       = err;
`endif

  // Sequencer FSM with all bus outputs registered. reg_idx runs one step ahead
  // of the entry being written: it advances on the second-to-last cycle of an
  // entry so that the table word for the next entry is already valid at the
  // edge where it is captured into vic_ain/vic_di.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      i         <= '0;
      k         <= '0;
      reg_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      vic_ain   <= '0;
      vic_di    <= '0;
      vic_cs    <= 1'b0;
      vic_we    <= 1'b0;
`ifdef SEQ_VERIFY_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            i       <= '0;
            k       <= '0;
            reg_idx <= '0;
`ifdef SEQ_VERIFY_EN
            err     <= 1'b0;
`endif
            if (FILL_LEN > 0) begin
              state     <= S_FILL;
              ram_we    <= 1'b1;
              ram_addr  <= fill_addr('0);
              ram_wdata <= fill_word('0);
            end else begin
              state     <= S_GAP;
              ram_addr  <= '0;
            end
          end
        end

        S_FILL: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (i == I_LAST) begin
              i         <= '0;
              ram_we    <= 1'b0;
              ram_addr  <= '0;
              ram_wdata <= '0;
`ifdef SEQ_VERIFY_EN
              state     <= S_VERIFY;
`else
              state     <= S_GAP;
`endif
            end else begin
              i         <= i_nxt;
              ram_addr  <= fill_addr(i_nxt);
              ram_wdata <= fill_word(i_nxt);
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end

`ifdef SEQ_VERIFY_EN
        S_VERIFY: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (bus.ram_rdata != fill_word(i)) begin
              err <= 1'b1;
            end
            if (i == I_LAST) begin
              i        <= '0;
              ram_addr <= '0;
              state    <= S_GAP;
            end else begin
              i        <= i_nxt;
              ram_addr <= fill_addr(i_nxt);
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
`endif

        S_GAP: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (NREG > 0) begin
              state   <= S_REGS;
              vic_cs  <= 1'b1;
              vic_we  <= 1'b1;
              vic_ain <= bus.reg_entry[13:8];
              vic_di  <= DATA_WIDTH'(bus.reg_entry[7:0]);
            end else begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end

        S_REGS: begin
          if (cnt == C_PRE && k != K_LAST) begin
            reg_idx <= k_nxt;
          end
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (k == K_LAST) begin
              state   <= S_DONE;
              vic_cs  <= 1'b0;
              vic_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k       <= k_nxt;
              vic_ain <= bus.reg_entry[13:8];
              vic_di  <= DATA_WIDTH'(bus.reg_entry[7:0]);
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vicii_boot_sequencer.sv
// Directed bench for vicii_boot_sequencer: RAM fill, gap, register replay,
// start handling, asynchronous reset mid-fill, an empty configuration, and
// (with SEQ_VERIFY_EN) readback error detection against a faulty RAM model.
module tb_vicii_boot_sequencer;

`ifdef SEQ_VERIFY_EN
  localparam int VERIFY_CYC = 8000;
`else
  localparam int VERIFY_CYC = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [13:0] tbl [0:15];
  logic [11:0] mem [0:4095];

  vicii_boot_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .IDX_WIDTH(4)) bus ();
  vicii_boot_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .IDX_WIDTH(4)) bus0 ();

  vicii_boot_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  vicii_boot_sequencer #(.FILL_LEN(0), .NREG(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  always #5 clk = ~clk;

  // Asynchronous register table and a RAM model.
  assign bus.reg_entry  = tbl[bus.reg_idx];
  assign bus0.reg_entry = 14'h0;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end

`ifdef SEQ_VERIFY_EN
  // Address 37 is stuck at zero on readback.
  assign bus.ram_rdata  = (bus.ram_addr == 12'd37) ? 12'h000 : mem[bus.ram_addr];
  assign bus0.ram_rdata = 12'h000;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) bus.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus0.start = 1'b0;
  endtask

  initial begin
    int n;
    int c;
    logic seen;
    clk       = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus0.start = 1'b0;
    n_tests   = 0;
    n_fail    = 0;
    tbl[0] = {6'h18, 8'h04};
    tbl[1] = {6'h20, 8'h0E};
    tbl[2] = {6'h21, 8'h00};
    tbl[3] = {6'h11, 8'h98};
    tbl[4] = {6'h16, 8'hC8};
    for (int j = 5; j < 16; j++) tbl[j] = 14'h3FFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.busy, bus.done, bus.ram_we, bus.vic_cs, bus.vic_we,
                        bus.reg_idx, bus.vic_ain}), 32'd0);
    chk("rst_ram", 32'({bus.ram_addr, bus.ram_wdata}), 32'd0);
    chk("rst_vic_di", 32'(bus.vic_di), 32'd0);
`ifdef SEQ_VERIFY_EN
    chk("rst_err", 32'(bus.err), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full fill
    pulse_start(0);
    chk("t1_busy", 32'({bus.busy, bus.done}), 32'h2);
    chk("t1_w0", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), {7'd0, 1'b1, 12'd0, 12'h800});
    n = 0;
    while (bus.ram_we && n < 9000) begin
      if (n == 7) chk("t1_w0_hold", 32'({bus.ram_addr, bus.ram_wdata}), {8'd0, 12'd0, 12'h800});
      if (n == 8) chk("t1_w1", 32'({bus.ram_addr, bus.ram_wdata}), {8'd0, 12'd1, 12'h801});
      if (n == 7992) chk("t1_w999", 32'({bus.ram_addr, bus.ram_wdata}), {8'd0, 12'd999, 12'h8E7});
      n++;
      @(negedge clk);
    end
    chk("t1_fill_len", 32'(n), 32'd8000);
    chk("t1_mem0", 32'(mem[0]), 32'h800);
    chk("t1_mem256", 32'(mem[256]), 32'h800);
    chk("t1_mem255", 32'(mem[255]), 32'h8FF);
    chk("t1_mem999", 32'(mem[999]), 32'h8E7);

`ifdef SEQ_VERIFY_EN
    // Readback pass; word 37 reads back wrong.
    for (int v = 0; v < 8000; v++) begin
      if (v == 0) chk("t6_vfy_start", 32'({bus.ram_we, bus.ram_addr, bus.busy}), 32'd1);
      if (v == 8) chk("t6_vfy_w1", 32'(bus.ram_addr), 32'd1);
      if (v == 303) chk("t6_err_before", 32'(bus.err), 32'd0);
      if (v == 304) chk("t6_err_after", 32'(bus.err), 32'd1);
      @(negedge clk);
    end
`endif

    // Gap
    chk("t2_gap0", 32'({bus.ram_we, bus.vic_cs, bus.ram_addr, bus.busy}), 32'd1);
    n = 0;
    while (!bus.vic_cs && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t2_gap_len", 32'(n), 32'd8);

    // Register replay
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_idx%0d", k), 32'(bus.reg_idx), 32'(k));
      chk($sformatf("t2_ain%0d", k), 32'(bus.vic_ain), 32'(tbl[k][13:8]));
      chk($sformatf("t2_di%0d", k), 32'(bus.vic_di), 32'(tbl[k][7:0]));
      c = 0;
      for (int j = 0; j < 8; j++) begin
        if (bus.vic_cs && bus.vic_we && bus.vic_ain == tbl[k][13:8]) c++;
        @(negedge clk);
      end
      chk($sformatf("t2_hold%0d", k), 32'(c), 32'd8);
    end
    chk("t2_done", 32'({bus.done, bus.busy, bus.vic_cs, bus.vic_we}), 32'h8);
`ifdef SEQ_VERIFY_EN
    chk("t6_err_done", 32'(bus.err), 32'd1);
`endif

    // Restart from DONE; start during REGS is ignored
    pulse_start(0);
    chk("t5_restart", 32'({bus.done, bus.busy, bus.ram_we, bus.ram_addr}), {16'd0, 1'b0, 1'b1, 1'b1, 12'd0});
`ifdef SEQ_VERIFY_EN
    chk("t6_err_clear", 32'(bus.err), 32'd0);
`endif
    n = 0;
    while (!bus.vic_cs && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("t5_to_regs", 32'(n), 32'(8008 + VERIFY_CYC));
    pulse_start(0);
    chk("t5_ignored", 32'({bus.busy, bus.vic_cs, bus.ram_we, bus.done}), 32'hC);
    chk("t5_ain", 32'(bus.vic_ain), 32'(tbl[0][13:8]));
    n = 2;
    while (!bus.done && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t5_regs_len", 32'(n), 32'd40);

    // Asynchronous reset mid-fill at word 300
    pulse_start(0);
    repeat (2403) @(negedge clk);
    chk("t4_w300", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), {7'd0, 1'b1, 12'd300, 12'h82C});
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ctl", 32'({bus.busy, bus.done, bus.ram_we, bus.vic_cs, bus.vic_we,
                           bus.reg_idx, bus.vic_ain}), 32'd0);
    chk("t4_rst_ram", 32'({bus.ram_addr, bus.ram_wdata}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle", 32'({bus.busy, bus.done, bus.ram_we, bus.ram_addr}), 32'd0);
    pulse_start(0);
    chk("t4_refill", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), {7'd0, 1'b1, 12'd0, 12'h800});

    // Empty configuration: gap only
    pulse_start(1);
    chk("t3_busy", 32'({bus0.busy, bus0.done}), 32'h2);
    n = 0;
    seen = 1'b0;
    while (!bus0.done && n < 50) begin
      if (bus0.ram_we || bus0.vic_cs) seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("t3_gap_len", 32'(n), 32'd8);
    chk("t3_no_strobe", 32'(seen), 32'd0);
    chk("t3_done", 32'({bus0.done, bus0.busy}), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
